atm_rx_cell_buffer: RTL and testbench
=====================================

# atm_rx_cell_buffer

Cell-assembly buffer upstream of one `atm_router` receive port. It accepts a byte stream of 53-byte ATM cells from the line-side framer and checks each cell's header HEC. It stores up to CELL_DEPTH good cells and serves them to the router over the UTOPIA-style Rx signals (data, soc, en, clav). One instance sits in front of each of Rx0..Rx3.

## Interface
Parameters:
- CELL_DEPTH, 4: number of 53-byte cell slots (2..16).
- HEC_CHECK, 1: 1 = drop cells with a bad HEC; 0 = accept all cells, but still count HEC errors.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  line byte present.
- in_data  in  8  line byte.
- in_soc  in  1  marks byte 0 of a cell; qualified by in_valid.
- in_ready  out  1  buffer can accept a byte; a byte transfers when in_valid && in_ready.
- rx_clav  out  1  at least one complete good cell is stored.
- rx_en  in  1  router read enable, active-high.
- rx_data  out  8  cell byte to the router.
- rx_soc  out  1  high with byte 0 of a cell on rx_data.
- rx_valid  out  1  rx_data carries a cell byte.
- hec_err_cnt  out  16  count of cells with a bad HEC; saturates at 0xFFFF.
- frame_err_cnt  out  16  count of framing errors (definition under Write side); saturates at 0xFFFF.

## Operation
Storage: CELL_DEPTH×53 bytes, organised as cell slots in a ring. The write slot pointer, read slot pointer and committed count (width $clog2(CELL_DEPTH+1)) are all registered.

Write side, states W_IDLE and W_CELL:
- in_ready = (count < CELL_DEPTH). It does not depend on the write state.
- W_IDLE:
  - A transfer with in_soc=1 stores the byte at index 0 and moves to W_CELL.
  - A transfer with in_soc=0 drops the byte and increments frame_err_cnt.
- W_CELL:
  - Each transfer stores the byte at the next index.
  - A transfer with in_soc=1 at index 1..52 aborts the partial cell, increments frame_err_cnt, and restarts the cell at index 0 with this byte.
- HEC:
  - CRC-8, polynomial x^8+x^2+x+1, initial value 0x00, computed MSB-first over bytes 0..3, then XORed with 0x55.
  - Compared against byte 4 when byte 4 is stored.
  - A mismatch increments hec_err_cnt once per cell.
- Commit on byte 52:
  - If the HEC is good, or HEC_CHECK=0: commit the slot (count+1, write slot+1) and return to W_IDLE.
  - If the HEC is bad and HEC_CHECK=1: discard the slot (no commit) and return to W_IDLE.

Read side, states R_IDLE and R_SEND, with a byte index 0..52:
- R_IDLE: if rx_en && count≠0, move to R_SEND with index 0.
- R_SEND: on each clock edge where rx_en=1, register rx_data=byte[index], rx_valid=1, rx_soc=(index==0), then increment index.
- R_SEND with rx_en=0: rx_valid=0 next cycle and the index holds (pause).
- On the edge that presents byte 52:
  - Free the slot (count−1, read slot+1).
  - If rx_en && count_after≠0, continue with index 0 of the next cell back-to-back. Otherwise go to R_IDLE.
- rx_clav = (count≠0), decoded from the registered count.

General rules:
- A commit and a free on the same edge leave count unchanged.
- Pointers wrap from CELL_DEPTH−1 to 0.
- A cell in progress on the write side is never visible on the read side.

## Timing
- Reset, sampled on a rising clk:
  - Pointers, count, error counters: 0.
  - States: W_IDLE and R_IDLE.
  - Outputs: rx_data=0x00, rx_soc=0, rx_valid=0, rx_clav=0, in_ready=1.
  - All stored cells and any partial cell are discarded.
- Reset mid-operation: the next cycle is identical to post-reset. A cell partially read is lost without a closing byte.
- Write latency: rx_clav rises on the cycle after the edge that stores a good byte 52.
- Read latency: byte 0 appears one cycle after the first rx_en=1 edge with count≠0. A full cell takes 53 cycles with rx_en held high.
- in_ready falls on the cycle after the commit that makes count=CELL_DEPTH. It rises on the cycle after a free.

## Test plan
- Idle cell: header 00 00 00 01, HEC 0x52, payload 0x6A×48; then rx_en held high → rx_clav=1; 53 bytes out with rx_soc only on 0x00; byte 4=0x52; rx_clav=0 after the last byte.
- Bad HEC: header 00 00 00 00, HEC 0x54 → hec_err_cnt=1, rx_clav stays 0. Repeat with HEC_CHECK=0 → cell delivered, hec_err_cnt=2.
- Framing: in_soc at index 20 of cell A, then a complete good cell B → frame_err_cnt=1, only B delivered. A stray byte with in_soc=0 in W_IDLE → frame_err_cnt=2.
- Full/wrap: write CELL_DEPTH+2 good cells with no reads → in_ready=0 after CELL_DEPTH cells. Then read continuously → all cells delivered in order through the pointer wrap, with back-to-back rx_soc spacing of 53 cycles.
- Simultaneous commit/free: byte 52 of cell N+1 written on the same edge that presents byte 52 of cell N → count unchanged, rx_clav stays 1.
- Pause and reset: drop rx_en for 5 cycles mid-cell → index holds and no bytes are lost. Assert rst mid-cell → outputs return to their reset values next cycle and count=0.

Source files
------------

// File: rtl/atm_rx_cell_buffer_if.sv
// Line-side byte stream and UTOPIA-style Rx signals of one atm_rx_cell_buffer.
// The buffer is the slave on both sides: the framer pushes bytes in and the
// router pulls cells out with rx_en.
interface atm_rx_cell_buffer_if;
    // Line side (framer -> buffer)
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_soc;
    logic       in_ready;
    // Router side (buffer -> router)
    logic       rx_clav;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_soc;
    logic       rx_valid;

    modport slave (
        input  in_valid, in_data, in_soc, rx_en,
        output in_ready, rx_clav, rx_data, rx_soc, rx_valid
    );

    modport master (
        output in_valid, in_data, in_soc, rx_en,
        input  in_ready, rx_clav, rx_data, rx_soc, rx_valid
    );
endinterface

// File: rtl/atm_rx_cell_buffer.sv
// Receive cell buffer for one atm_router port: assembles 53-byte cells from the
// line byte stream, checks the header HEC, holds up to CELL_DEPTH good cells in
// a ring of slots and replays them byte-serially to the router.
module atm_rx_cell_buffer #(
    parameter int CELL_DEPTH = 4,    // 2..16 cell slots
    parameter bit HEC_CHECK  = 1'b1  // 1: drop bad-HEC cells, 0: keep them (still counted)
) (
    input  logic                 clk,
    input  logic                 rst,
    atm_rx_cell_buffer_if.slave  bus,
    output logic [15:0]          hec_err_cnt,
    output logic [15:0]          frame_err_cnt
);

    localparam int CELL_BYTES = 53;
    localparam int CW = $clog2(CELL_DEPTH + 1);
    localparam int PW = $clog2(CELL_DEPTH);
    localparam int AW = $clog2(CELL_DEPTH * CELL_BYTES);

    typedef enum logic {W_IDLE, W_CELL} wr_state_e;
    typedef enum logic {R_IDLE, R_SEND} rd_state_e;

    // CRC-8 (x^8+x^2+x+1) advanced by one byte, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] s);
        return (s == PW'(CELL_DEPTH - 1)) ? '0 : s + PW'(1);
    endfunction

    function automatic logic [AW-1:0] slot_addr(input logic [PW-1:0] s, input logic [5:0] i);
        return AW'(int'(s) * CELL_BYTES + int'(i));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Cell storage: one 53-byte slot per cell.
    logic [7:0] mem [CELL_DEPTH * CELL_BYTES];

    wr_state_e      wr_state_q, wr_state_d;
    logic [5:0]     wr_idx_q,   wr_idx_d;
    logic [PW-1:0]  wr_slot_q,  wr_slot_d;
    logic [7:0]     crc_q,      crc_d;
    logic           hec_bad_q,  hec_bad_d;
    rd_state_e      rd_state_q, rd_state_d;
    logic [5:0]     rd_idx_q,   rd_idx_d;
    logic [PW-1:0]  rd_slot_q,  rd_slot_d;
    logic [CW-1:0]  count_q,    count_d;
    logic [15:0]    hec_err_q,  hec_err_d;
    logic [15:0]    frame_err_q, frame_err_d;
    logic [7:0]     rx_data_q,  rx_data_d;
    logic           rx_soc_q,   rx_soc_d;
    logic           rx_valid_q, rx_valid_d;

    logic           in_ready;
    logic           wr_fire;
    logic           commit;
    logic           free;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [7:0]     mem_wdata;

    // Backpressure depends only on committed cells, never on the write state.
    assign in_ready = (count_q < CW'(CELL_DEPTH));
    assign wr_fire  = bus.in_valid && in_ready;

    // Next-state logic for cell assembly, cell replay and the shared cell count.
    always_comb begin
        // NOTE: every _d starts from its _q value so no branch can leave it unassigned and infer a latch.
        wr_state_d  = wr_state_q;
        wr_idx_d    = wr_idx_q;
        wr_slot_d   = wr_slot_q;
        crc_d       = crc_q;
        hec_bad_d   = hec_bad_q;
        rd_state_d  = rd_state_q;
        rd_idx_d    = rd_idx_q;
        rd_slot_d   = rd_slot_q;
        count_d     = count_q;
        hec_err_d   = hec_err_q;
        frame_err_d = frame_err_q;
        rx_data_d   = rx_data_q;
        rx_soc_d    = 1'b0;
        rx_valid_d  = 1'b0;
        commit      = 1'b0;
        free        = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = slot_addr(wr_slot_q, wr_idx_q);
        mem_wdata   = bus.in_data;

        // Write side: any SOC restarts the cell at index 0; an SOC mid-cell is a framing error.
        if (wr_fire) begin
            if (bus.in_soc) begin
                if (wr_state_q == W_CELL) begin
                    frame_err_d = sat_inc(frame_err_q);
                end
                mem_we     = 1'b1;
                mem_waddr  = slot_addr(wr_slot_q, 6'd0);
                crc_d      = crc8_byte(8'h00, bus.in_data);
                hec_bad_d  = 1'b0;
                wr_idx_d   = 6'd1;
                wr_state_d = W_CELL;
            end else if (wr_state_q == W_IDLE) begin
                frame_err_d = sat_inc(frame_err_q);
            end else begin
                mem_we   = 1'b1;
                wr_idx_d = wr_idx_q + 6'd1;
                if (wr_idx_q < 6'd4) begin
                    crc_d = crc8_byte(crc_q, bus.in_data);
                end
                if (wr_idx_q == 6'd4 && bus.in_data != (crc_q ^ 8'h55)) begin
                    hec_err_d = sat_inc(hec_err_q);
                    hec_bad_d = 1'b1;
                end
                if (wr_idx_q == 6'd52) begin
                    wr_state_d = W_IDLE;
                    wr_idx_d   = 6'd0;
                    commit     = !hec_bad_q || !HEC_CHECK;
                end
            end
        end

        // Read side: one byte per rx_en edge; rx_en low pauses with the index held.
        case (rd_state_q)
            R_IDLE: begin
                if (bus.rx_en && count_q != '0) begin
                    rd_state_d = R_SEND;
                    rd_idx_d   = 6'd0;
                end
            end
            R_SEND: begin
                if (bus.rx_en) begin
                    rx_data_d  = mem[slot_addr(rd_slot_q, rd_idx_q)];
                    rx_valid_d = 1'b1;
                    rx_soc_d   = (rd_idx_q == 6'd0);
                    if (rd_idx_q == 6'd52) begin
                        free      = 1'b1;
                        rd_idx_d  = 6'd0;
                        rd_slot_d = next_slot(rd_slot_q);
                    end else begin
                        rd_idx_d = rd_idx_q + 6'd1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        // A commit and a free on the same edge cancel out.
        case ({commit, free})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (commit) begin
            wr_slot_d = next_slot(wr_slot_q);
        end
        // Continue back-to-back only while another committed cell is waiting.
        if (free && count_d == '0) begin
            rd_state_d = R_IDLE;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_state_q  <= W_IDLE;
            wr_idx_q    <= '0;
            wr_slot_q   <= '0;
            crc_q       <= '0;
            hec_bad_q   <= 1'b0;
            rd_state_q  <= R_IDLE;
            rd_idx_q    <= '0;
            rd_slot_q   <= '0;
            count_q     <= '0;
            hec_err_q   <= '0;
            frame_err_q <= '0;
            rx_data_q   <= '0;
            rx_soc_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_idx_q    <= wr_idx_d;
            wr_slot_q   <= wr_slot_d;
            crc_q       <= crc_d;
            hec_bad_q   <= hec_bad_d;
            rd_state_q  <= rd_state_d;
            rd_idx_q    <= rd_idx_d;
            rd_slot_q   <= rd_slot_d;
            count_q     <= count_d;
            hec_err_q   <= hec_err_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_soc_q    <= rx_soc_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    // Cell storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; clearing count and pointers already makes every slot unreachable.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.rx_clav    = (count_q != '0);
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_soc     = rx_soc_q;
    assign bus.rx_valid   = rx_valid_q;
    assign hec_err_cnt    = hec_err_q;
    assign frame_err_cnt  = frame_err_q;

endmodule

// File: tb/tb_atm_rx_cell_buffer.sv
// Directed bench for atm_rx_cell_buffer: dut0 (4 slots, HEC check on) and
// dut1 (2 slots, HEC check off). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_atm_rx_cell_buffer;

    typedef struct packed {
        logic [31:0] hdr;
        logic [7:0]  hec;
        logic [7:0]  pay;
    } cell_t;

    logic        clk;
    logic        rst;
    logic [15:0] hec0, frame0, hec1, frame1;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    atm_rx_cell_buffer_if bus0 ();
    atm_rx_cell_buffer_if bus1 ();

    atm_rx_cell_buffer #(.CELL_DEPTH(4), .HEC_CHECK(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .hec_err_cnt(hec0), .frame_err_cnt(frame0)
    );

    atm_rx_cell_buffer #(.CELL_DEPTH(2), .HEC_CHECK(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .hec_err_cnt(hec1), .frame_err_cnt(frame1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // HEC model: bit-serial CRC-8 over the 32 header bits, then XOR 0x55.
    function automatic logic [7:0] hec_of(input logic [31:0] hdr);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int b = 31; b >= 0; b--) begin
            fb  = crc[7] ^ hdr[b];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc ^ 8'h55;
    endfunction

    function automatic cell_t good_cell(input logic [31:0] hdr, input logic [7:0] pay);
        return cell_t'{hdr: hdr, hec: hec_of(hdr), pay: pay};
    endfunction

    function automatic logic [7:0] exp_byte(input cell_t c, input int i);
        if (i < 4)  return c.hdr[31-8*i -: 8];
        if (i == 4) return c.hec;
        return c.pay;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? bus1.in_ready : bus0.in_ready;
    endfunction
    function automatic logic get_valid(input bit sel);
        return sel ? bus1.rx_valid : bus0.rx_valid;
    endfunction
    function automatic logic get_soc(input bit sel);
        return sel ? bus1.rx_soc : bus0.rx_soc;
    endfunction
    function automatic logic get_clav(input bit sel);
        return sel ? bus1.rx_clav : bus0.rx_clav;
    endfunction
    function automatic logic [7:0] get_data(input bit sel);
        return sel ? bus1.rx_data : bus0.rx_data;
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d, input logic s);
        if (sel) begin
            bus1.in_valid = v; bus1.in_data = d; bus1.in_soc = s;
        end else begin
            bus0.in_valid = v; bus0.in_data = d; bus0.in_soc = s;
        end
    endtask

    task automatic set_en(input bit sel, input logic en);
        if (sel) bus1.rx_en = en;
        else     bus0.rx_en = en;
    endtask

    // Push the first nbytes of a cell, waiting (bounded) on in_ready.
    task automatic write_cell(input bit sel, input cell_t c, input int nbytes);
        int w;
        for (int i = 0; i < nbytes; i++) begin
            set_in(sel, 1'b1, exp_byte(c, i), (i == 0));
            w = 0;
            while (!get_ready(sel) && w < 400) begin
                tick();
                w++;
            end
            if (!get_ready(sel)) begin
                check("wr_ready_timeout", get_ready(sel), 1);
                set_in(sel, 1'b0, 8'h00, 1'b0);
                return;
            end
            tick();
        end
        set_in(sel, 1'b0, 8'h00, 1'b0);
    endtask

    // Hold rx_en high and collect one cell; optionally pause 5 cycles after byte pause_at.
    task automatic read_cell(input bit sel, input cell_t c, input int pause_at, output int soc_cyc);
        int bad;
        int w;
        bad     = 0;
        soc_cyc = -1;
        set_en(sel, 1'b1);
        for (int i = 0; i < 53; i++) begin
            tick();
            w = 0;
            while (!get_valid(sel) && w < 200) begin
                tick();
                w++;
            end
            if (!get_valid(sel)) begin
                check("rd_valid_timeout", get_valid(sel), 1);
                return;
            end
            if (i == 0) soc_cyc = cyc;
            if (get_soc(sel) !== (i == 0)) bad++;
            if (get_data(sel) !== exp_byte(c, i)) bad++;
            if (i == pause_at) begin
                set_en(sel, 1'b0);
                repeat (5) begin
                    tick();
                    if (get_valid(sel) !== 1'b0) bad++;
                end
                set_en(sel, 1'b1);
            end
        end
        check("cell_bytes", 16'(bad), 0);
    endtask

    cell_t c_idle, c_bad, c_a, c_b, c_n, c_n1, c_p, r1, r2, r3, r4;
    cell_t f [6];
    int    soc_t [6];
    int    t0, t1, tdummy;

    initial begin
        rst = 1'b1;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        set_en(0, 1'b0);
        set_en(1, 1'b0);
        repeat (3) tick();

        // Reset values
        check("rst_rx_data",  get_data(0), 8'h00);
        check("rst_rx_soc",   get_soc(0), 0);
        check("rst_rx_valid", get_valid(0), 0);
        check("rst_rx_clav",  get_clav(0), 0);
        check("rst_in_ready", get_ready(0), 1);
        check("rst_hec_cnt",  hec0, 0);
        check("rst_frame_cnt", frame0, 0);
        check("rst_in_ready1", get_ready(1), 1);
        rst = 1'b0;
        tick();

        // Idle cell: header 00 00 00 01, HEC 0x52, payload 0x6A
        c_idle = cell_t'{hdr: 32'h00000001, hec: 8'h52, pay: 8'h6A};
        write_cell(0, c_idle, 53);
        check("idle_clav_after_commit", get_clav(0), 1);
        read_cell(0, c_idle, -1, tdummy);
        check("idle_clav_after_read", get_clav(0), 0);
        set_en(0, 1'b0);
        tick();

        // Bad HEC on the checking instance: counted and dropped
        c_bad = cell_t'{hdr: 32'h00000000, hec: 8'h54, pay: 8'h11};
        write_cell(0, c_bad, 53);
        check("badhec_cnt", hec0, 1);
        check("badhec_clav", get_clav(0), 0);

        // Framing: SOC at index 20 of A, then good B; then a stray non-SOC byte
        c_a = good_cell(32'h0A0B0C0D, 8'hA5);
        c_b = good_cell(32'h01020304, 8'hB6);
        write_cell(0, c_a, 20);
        write_cell(0, c_b, 53);
        check("frame_abort_cnt", frame0, 1);
        check("frame_b_clav", get_clav(0), 1);
        check("frame_hec_unchanged", hec0, 1);
        set_in(0, 1'b1, 8'hAB, 1'b0);
        tick();
        set_in(0, 1'b0, 8'h00, 1'b0);
        check("frame_stray_cnt", frame0, 2);
        read_cell(0, c_b, -1, tdummy);
        check("frame_only_b", get_clav(0), 0);
        set_en(0, 1'b0);
        tick();

        // HEC check disabled: bad cell delivered, errors still counted
        c_bad.pay = 8'h22;
        write_cell(1, c_bad, 53);
        check("nochk_hec_cnt1", hec1, 1);
        check("nochk_clav", get_clav(1), 1);
        read_cell(1, c_bad, -1, tdummy);
        set_en(1, 1'b0);
        check("nochk_clav_after_read", get_clav(1), 0);
        c_bad.pay = 8'h33;
        write_cell(1, c_bad, 53);
        check("nochk_hec_cnt2", hec1, 2);
        check("nochk_frame_cnt", frame1, 0);

        // Full and wrap: fill all 4 slots, then read 6 cells while 2 more are written
        for (int k = 0; k < 6; k++) f[k] = good_cell({24'h00F000, 8'(k + 1)}, 8'(8'h40 + k));
        for (int k = 0; k < 4; k++) begin
            write_cell(0, f[k], 53);
            check($sformatf("full_in_ready_%0d", k), get_ready(0), (k < 3) ? 1 : 0);
        end
        check("full_clav", get_clav(0), 1);
        fork
            begin
                for (int k = 0; k < 6; k++) read_cell(0, f[k], -1, soc_t[k]);
            end
            begin
                write_cell(0, f[4], 53);
                write_cell(0, f[5], 53);
            end
        join
        for (int k = 1; k < 6; k++) check($sformatf("wrap_soc_spacing_%0d", k), 16'(soc_t[k] - soc_t[k-1]), 53);
        check("wrap_drained_clav", get_clav(0), 0);
        check("wrap_in_ready", get_ready(0), 1);
        set_en(0, 1'b0);
        tick();

        // Commit of cell N+1 on the same edge that presents byte 52 of cell N
        c_n  = good_cell(32'h00ABCDEF, 8'h77);
        c_n1 = good_cell(32'h12345678, 8'h88);
        write_cell(0, c_n, 53);
        fork
            read_cell(0, c_n, -1, t0);
            begin
                tick();
                write_cell(0, c_n1, 53);
            end
        join
        check("commit_free_clav", get_clav(0), 1);
        read_cell(0, c_n1, -1, t1);
        check("commit_free_b2b", 16'(t1 - t0), 53);
        check("commit_free_drained", get_clav(0), 0);
        set_en(0, 1'b0);
        tick();

        // Pause: rx_en low for 5 cycles after byte 2
        c_p = good_cell(32'h11223344, 8'hC3);
        write_cell(0, c_p, 53);
        read_cell(0, c_p, 2, tdummy);
        check("pause_drained", get_clav(0), 0);
        set_en(0, 1'b0);
        tick();

        // Reset mid-read with a partial cell on the write side
        r1 = good_cell(32'h0000A001, 8'h51);
        r2 = good_cell(32'h0000A002, 8'h52);
        r3 = good_cell(32'h0000A003, 8'h53);
        r4 = good_cell(32'h0000A004, 8'h54);
        write_cell(0, r1, 53);
        write_cell(0, r2, 53);
        write_cell(0, r3, 10);
        set_en(0, 1'b1);
        repeat (8) tick();
        check("pre_rst_valid", get_valid(0), 1);
        rst = 1'b1;
        tick();
        check("midrst_rx_data",  get_data(0), 8'h00);
        check("midrst_rx_soc",   get_soc(0), 0);
        check("midrst_rx_valid", get_valid(0), 0);
        check("midrst_rx_clav",  get_clav(0), 0);
        check("midrst_in_ready", get_ready(0), 1);
        check("midrst_hec_cnt",  hec0, 0);
        check("midrst_frame_cnt", frame0, 0);
        check("midrst_clav1",    get_clav(1), 0);
        check("midrst_hec_cnt1", hec1, 0);
        set_en(0, 1'b0);
        rst = 1'b0;
        tick();
        write_cell(0, r4, 53);
        check("post_rst_frame_cnt", frame0, 0);
        check("post_rst_clav", get_clav(0), 1);
        read_cell(0, r4, -1, tdummy);
        check("post_rst_drained", get_clav(0), 0);
        set_en(0, 1'b0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
